// File: rtl/serial_word_deserializer.sv
// Receive side of a serial shift path: assembles WIDTH-bit words from a qualified
// bit stream, with per-word bit order, a valid/ready output register and error flags.
`timescale 1ns/1ps
module serial_word_deserializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             msb_first,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] sreg_reg;
  logic [WIDTH-1:0] sreg_next;
  logic [CNT_W-1:0] count_reg;
  logic             order_reg;
  logic             order_next;
  logic             start;
  logic             advance;
  logic             complete;

  // A frame_start always wins, so a start on the last bit restarts rather than completes.
  assign start      = bit_valid & frame_start;
  assign advance    = bit_valid & ~frame_start & (state_reg == SHIFT);
  assign complete   = advance & (count_reg == CNT_W'(WIDTH - 1));
  assign order_next = start ? msb_first : order_reg;
  assign busy       = (state_reg == SHIFT);

  always_comb begin
    sreg_next = sreg_reg;
    if (order_next) begin
      sreg_next = {sreg_reg[WIDTH-2:0], serial_in};
    end else begin
      sreg_next = {serial_in, sreg_reg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      sreg_reg     <= '0;
      count_reg    <= '0;
      order_reg    <= 1'b0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (start) begin
        frame_err <= (state_reg == SHIFT);
        order_reg <= msb_first;
        sreg_reg  <= sreg_next;
        count_reg <= CNT_W'(1);
        state_reg <= SHIFT;
      end else if (advance) begin
        sreg_reg <= sreg_next;
        if (complete) begin
          count_reg <= '0;
          state_reg <= IDLE;
        end else begin
          count_reg <= count_reg + CNT_W'(1);
        end
      end

      // An accept on the completion edge frees the register for the new word.
      if (complete) begin
        if (!out_valid || out_ready) begin
          parallel_out <= sreg_next;
          out_valid    <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
